// File: rtl/btn_cond_pkg.sv
// ---------------------------------------------------------------------------
// btn_cond_pkg
// Shared constants for the button conditioner:
//   - the 2-bit per-button behaviour codes carried in control register 4
//   - the default debounce length in sysclk cycles
// ---------------------------------------------------------------------------
package btn_cond_pkg;

    // Per-button behaviour codes (btn_mode[2i+1:2i])
    localparam logic [1:0] BTN_MODE_PASS   = 2'b00;  // synchronized raw level, no debounce
    localparam logic [1:0] BTN_MODE_LEVEL  = 2'b01;  // debounced level
    localparam logic [1:0] BTN_MODE_PULSE  = 2'b10;  // one-cycle pulse per accepted press
    localparam logic [1:0] BTN_MODE_TOGGLE = 2'b11;  // output flips on each accepted press

    // Cycles a new synchronized level must persist before it is accepted
    localparam int BTN_DEBOUNCE_DEFAULT = 1_000_000;

endpackage : btn_cond_pkg

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// One button: two-flop synchronizer followed by a persistence counter. A new
// synchronized level is accepted into 'stable' only after it has differed
// from 'stable' for DEBOUNCE_CYCLES consecutive cycles; any return to the
// current stable level restarts the count.
//
// Ports:
//   sysclk  in   clock
//   rst     in   synchronous active-high reset
//   raw     in   raw button level, asynchronous to sysclk
//   sync    out  synchronized level (second synchronizer flop)
//   stable  out  debounced level (registered)
// ---------------------------------------------------------------------------
module btn_debounce
    import btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT
) (
    input  logic sysclk,
    input  logic rst,
    input  logic raw,
    output logic sync,
    output logic stable
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        s1_d     = raw;
        s2_d     = s1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (the synchronizer chain
    // depends on this).
    always_ff @(posedge sysclk) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sync   = s2_q;
    assign stable = stable_q;

endmodule : btn_debounce

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
// Per-button conditioning between the AXI register file and the DUT. Each
// button gets its own synchronizer/debouncer (btn_debounce), then a rising
// edge detector on the debounced level and mode-selected output shaping.
//
// Ports:
//   sysclk      in   single clock
//   rst         in   synchronous active-high reset
//   btn_raw     in   [N_BTN-1:0]   raw button levels (asynchronous)
//   btn_mode    in   [2*N_BTN-1:0] behaviour code for button i in [2i+1:2i]
//   btn_out     out  [N_BTN-1:0]   conditioned button signals (registered)
//   btn_stable  out  [N_BTN-1:0]   debounced levels for the status register
// ---------------------------------------------------------------------------
module button_conditioner
    import btn_cond_pkg::*;
#(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT
) (
    input  logic                 sysclk,
    input  logic                 rst,
    input  logic [N_BTN-1:0]     btn_raw,
    input  logic [2*N_BTN-1:0]   btn_mode,
    output logic [N_BTN-1:0]     btn_out,
    output logic [N_BTN-1:0]     btn_stable
);

    logic [N_BTN-1:0] sync;
    logic [N_BTN-1:0] stable;
    logic [N_BTN-1:0] rise;

    logic [N_BTN-1:0] stable_d_q, stable_d_d;
    logic [N_BTN-1:0] tog_q,      tog_d;
    logic [N_BTN-1:0] btn_out_q,  btn_out_d;

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .sysclk (sysclk),
            .rst    (rst),
            .raw    (btn_raw[g]),
            .sync   (sync[g]),
            .stable (stable[g])
        );
    end

    always_comb begin
        rise       = stable & ~stable_d_q;
        stable_d_d = stable;
        tog_d      = '0;   // toggle state only survives while the mode is TOGGLE
        btn_out_d  = '0;
        for (int i = 0; i < N_BTN; i++) begin
            case (btn_mode[2*i +: 2])
                BTN_MODE_PASS:   btn_out_d[i] = sync[i];
                BTN_MODE_LEVEL:  btn_out_d[i] = stable[i];
                BTN_MODE_PULSE:  btn_out_d[i] = rise[i];
                BTN_MODE_TOGGLE: begin
                    tog_d[i]     = tog_q[i] ^ rise[i];
                    btn_out_d[i] = tog_d[i];
                end
                default: btn_out_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            stable_d_q <= '0;
            tog_q      <= '0;
            btn_out_q  <= '0;
        end else begin
            stable_d_q <= stable_d_d;
            tog_q      <= tog_d;
            btn_out_q  <= btn_out_d;
        end
    end

    assign btn_out    = btn_out_q;
    assign btn_stable = stable;

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
// Self-checking bench for button_conditioner with N_BTN=5, DEBOUNCE_CYCLES=4.
// Stimulus is applied on the falling edge; the expected btn_out/btn_stable
// after the following rising edge is pushed to a scoreboard queue and popped
// by a monitor 1 ns after that rising edge. Expected values come from the
// documented latencies relative to the first edge k that samples a change.
// ---------------------------------------------------------------------------
module tb_button_conditioner;
    import btn_cond_pkg::*;

    localparam int N_BTN = 5;
    localparam int DEB   = 4;

    logic                 sysclk;
    logic                 rst;
    logic [N_BTN-1:0]     btn_raw;
    logic [2*N_BTN-1:0]   btn_mode;
    logic [N_BTN-1:0]     btn_out;
    logic [N_BTN-1:0]     btn_stable;

    button_conditioner #(
        .N_BTN           (N_BTN),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_mode   (btn_mode),
        .btn_out    (btn_out),
        .btn_stable (btn_stable)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    typedef struct {
        string            tag;
        logic [N_BTN-1:0] out;
        logic [N_BTN-1:0] stb;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string tag, input logic [N_BTN-1:0] actual,
                         input logic [N_BTN-1:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("FAIL %s: got %b, want %b", tag, actual, expected);
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard after each edge.
    always @(posedge sysclk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check({mon_e.tag, " out"}, btn_out,    mon_e.out);
            check({mon_e.tag, " stb"}, btn_stable, mon_e.stb);
        end
    end

    function automatic logic [2*N_BTN-1:0] mk_mode(input logic [1:0] m4, input logic [1:0] m3,
                                                   input logic [1:0] m2, input logic [1:0] m1,
                                                   input logic [1:0] m0);
        return {m4, m3, m2, m1, m0};
    endfunction

    // Drive one cycle of stimulus and record what must be seen after the next edge.
    task automatic step(input logic r, input logic [N_BTN-1:0] raw,
                        input logic [2*N_BTN-1:0] mode, input logic [N_BTN-1:0] eo,
                        input logic [N_BTN-1:0] es, input string tag);
        exp_t e;
        @(negedge sysclk);
        rst      = r;
        btn_raw  = raw;
        btn_mode = mode;
        e.tag = tag;
        e.out = eo;
        e.stb = es;
        sb_q.push_back(e);
    endtask

    task automatic reset_dut(input logic [2*N_BTN-1:0] mode);
        step(1'b1, '0, mode, '0, '0, "rst0");
        step(1'b1, '0, mode, '0, '0, "rst1");
        step(1'b0, '0, mode, '0, '0, "idle");
    endtask

    logic [2*N_BTN-1:0] lvl_all, m;
    logic [N_BTN-1:0]   raw, eo, es;

    initial begin
        rst      = 1'b1;
        btn_raw  = '0;
        btn_mode = '0;
        lvl_all  = mk_mode(BTN_MODE_LEVEL, BTN_MODE_LEVEL, BTN_MODE_LEVEL,
                           BTN_MODE_LEVEL, BTN_MODE_LEVEL);

        // Reset with all buttons pressed in PASS mode: everything must be 0.
        step(1'b1, 5'h1F, '0, '0, '0, "reset_held_a");
        step(1'b1, 5'h1F, '0, '0, '0, "reset_held_b");

        // Debounce accept: button 0 in LEVEL.
        reset_dut(lvl_all);
        for (int t = 0; t < 12; t++) begin
            eo = (t >= 6) ? 5'b00001 : 5'b00000;
            es = (t >= 5) ? 5'b00001 : 5'b00000;
            step(1'b0, 5'b00001, lvl_all, eo, es, $sformatf("accept t=%0d", t));
        end

        // Glitch reject: button 1 high for 3 cycles.
        reset_dut(lvl_all);
        for (int t = 0; t < 12; t++) begin
            raw = (t < 3) ? 5'b00010 : 5'b00000;
            step(1'b0, raw, lvl_all, '0, '0, $sformatf("glitch t=%0d", t));
        end

        // Pulse: button 2, held 20 cycles, released.
        m = mk_mode(BTN_MODE_LEVEL, BTN_MODE_LEVEL, BTN_MODE_PULSE,
                    BTN_MODE_LEVEL, BTN_MODE_LEVEL);
        reset_dut(m);
        for (int t = 0; t < 35; t++) begin
            raw = (t < 20) ? 5'b00100 : 5'b00000;
            eo  = (t == 6) ? 5'b00100 : 5'b00000;
            es  = (t >= 5 && t < 25) ? 5'b00100 : 5'b00000;
            step(1'b0, raw, m, eo, es, $sformatf("pulse t=%0d", t));
        end

        // Toggle: button 3, three presses, then LEVEL and back to TOGGLE.
        m = mk_mode(BTN_MODE_LEVEL, BTN_MODE_TOGGLE, BTN_MODE_LEVEL,
                    BTN_MODE_LEVEL, BTN_MODE_LEVEL);
        reset_dut(m);
        for (int t = 0; t < 66; t++) begin
            raw = ((t < 10) || (t >= 20 && t < 30) || (t >= 40 && t < 50))
                  ? 5'b01000 : 5'b00000;
            es  = ((t >= 5 && t < 15) || (t >= 25 && t < 35) || (t >= 45 && t < 55))
                  ? 5'b01000 : 5'b00000;
            eo  = ((t >= 6 && t < 26) || (t >= 46 && t < 60)) ? 5'b01000 : 5'b00000;
            step(1'b0, raw, (t == 60 || t == 61) ? lvl_all : m, eo, es,
                 $sformatf("toggle t=%0d", t));
        end

        // Simultaneous: button 0 PASS, button 4 PULSE, pressed together.
        m = mk_mode(BTN_MODE_PULSE, BTN_MODE_LEVEL, BTN_MODE_LEVEL,
                    BTN_MODE_LEVEL, BTN_MODE_PASS);
        reset_dut(m);
        for (int t = 0; t < 25; t++) begin
            raw   = (t < 15) ? 5'b10001 : 5'b00000;
            eo    = '0;
            eo[0] = (t >= 2 && t < 17);
            eo[4] = (t == 6);
            es    = (t >= 5 && t < 20) ? 5'b10001 : 5'b00000;
            step(1'b0, raw, m, eo, es, $sformatf("simul t=%0d", t));
        end

        // Reset at count 2 with button 2 (PULSE) still held; debounce restarts
        // at the first post-reset edge (t=6).
        m = mk_mode(BTN_MODE_LEVEL, BTN_MODE_LEVEL, BTN_MODE_PULSE,
                    BTN_MODE_LEVEL, BTN_MODE_LEVEL);
        reset_dut(m);
        for (int t = 0; t < 21; t++) begin
            eo = (t == 12) ? 5'b00100 : 5'b00000;
            es = (t >= 11) ? 5'b00100 : 5'b00000;
            step((t == 4 || t == 5), 5'b00100, m, eo, es, $sformatf("midrst t=%0d", t));
        end

        // Let the monitor drain the scoreboard within a bounded number of edges.
        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge sysclk);
        #2;
        check("sb_drain", N_BTN'(sb_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_button_conditioner
